rob_tagged_reorder: RTL

Parametrised reorder buffer between a requester and an out-of-order memory. Each accepted request is forwarded to memory with a slot tag, and read data is returned to the requester strictly in acceptance order. Beyond a fixed-size reorder buffer, it adds configurable depth and ID/address/data widths, generation-bit tags for safe slot reuse, and a per-head timeout that retires a stuck entry with an error flag.

---
 rtl/rob_tagged_reorder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rob_tagged_reorder.sv
// rob_tagged_reorder: reorder buffer between a requester and an out-of-order memory.
// Each accepted request goes to memory tagged {gen, slot}. Read data is returned to the
// requester in acceptance order. A head entry that waits too long retires with rsp_err.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake; req_addr, req_id carried with the request
//   mem_valid/mem_ready         forwarded request; mem_addr = req_addr, mem_tag = {gen, slot}
//   mem_rsp_valid/tag/data      memory read data (no back-pressure)
//   rsp_valid/rsp_ready         in-order response; rsp_id, rsp_addr, rsp_data, rsp_err
//   drop                        one-cycle pulse: a memory response was discarded
//   count                       occupied slots, 0..DEPTH
module rob_tagged_reorder #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AWIDTH  = 4,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned IDWIDTH = 4,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [AWIDTH-1:0]        req_addr,
    input  logic [IDWIDTH-1:0]       req_id,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [AWIDTH-1:0]        mem_addr,
    output logic [$clog2(DEPTH):0]   mem_tag,
    input  logic                     mem_rsp_valid,
    input  logic [$clog2(DEPTH):0]   mem_rsp_tag,
    input  logic [DWIDTH-1:0]        mem_rsp_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDWIDTH-1:0]       rsp_id,
    output logic [AWIDTH-1:0]        rsp_addr,
    output logic [DWIDTH-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned AGE_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [PW:0]      FULL_COUNT = (PW+1)'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX    = AGE_W'(TIMEOUT);
    localparam logic             TO_EN      = (TIMEOUT != 0);

    // Slot storage
    logic [IDWIDTH-1:0] id_q      [DEPTH];
    logic [AWIDTH-1:0]  addr_q    [DEPTH];
    logic [DWIDTH-1:0]  data_q    [DEPTH];
    logic [DEPTH-1:0]   gen_q;
    logic [DEPTH-1:0]   pending_q;
    logic [DEPTH-1:0]   done_q;

    logic [PW:0]        wr_ptr;
    logic [PW:0]        rd_ptr;
    logic [AGE_W-1:0]   age;
    logic               drop_q;

    logic [PW:0]        count_nxt;
    logic [AGE_W-1:0]   age_nxt;
    logic [PW-1:0]      head;
    logic [PW-1:0]      wr_slot;
    logic [PW-1:0]      rsp_slot;
    logic               full;
    logic               occupied;
    logic               accept;
    logic               pop;
    logic               head_done;
    logic               expired;
    logic               rsp_write;
    logic               rsp_to_head;

    // Request path, head presentation and response qualification
    always_comb begin
        full      = (count == FULL_COUNT);
        occupied  = (count != '0);
        req_ready = mem_ready & ~full & ~rst;
        mem_valid = req_valid & ~full & ~rst;
        mem_addr  = req_addr;
        mem_tag   = wr_ptr;
        accept    = req_valid & req_ready;
        wr_slot   = wr_ptr[PW-1:0];

        head      = rd_ptr[PW-1:0];
        head_done = done_q[head];
        expired   = TO_EN & (age == AGE_MAX);
        rsp_valid = occupied & (head_done | expired);
        rsp_err   = occupied & expired & ~head_done;
        rsp_id    = id_q[head];
        rsp_addr  = addr_q[head];
        rsp_data  = rsp_err ? '0 : data_q[head];
        pop       = rsp_valid & rsp_ready;

        // An expired head refuses late data so the errored response cannot change under the requester
        rsp_slot    = mem_rsp_tag[PW-1:0];
        rsp_to_head = (rsp_slot == head);
        rsp_write   = mem_rsp_valid & pending_q[rsp_slot]
                    & (gen_q[rsp_slot] == mem_rsp_tag[PW])
                    & ~(rsp_to_head & expired);

        drop = drop_q;
    end

    // Occupancy and head-age next state
    always_comb begin
        count_nxt = count;
        age_nxt   = age;
        if (accept && !pop) begin
            count_nxt = count + (PW+1)'(1);
        end else if (pop && !accept) begin
            count_nxt = count - (PW+1)'(1);
        end
        // A write landing on the head this cycle stops the count, so data beats the timeout
        if (pop) begin
            age_nxt = '0;
        end else if (occupied && !head_done && (age < AGE_MAX) && !(rsp_write && rsp_to_head)) begin
            age_nxt = age + AGE_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            age       <= '0;
            drop_q    <= 1'b0;
            gen_q     <= '0;
            pending_q <= '0;
            done_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                id_q[i]   <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            count  <= count_nxt;
            age    <= age_nxt;
            drop_q <= mem_rsp_valid & ~rsp_write;

            if (accept) begin
                id_q[wr_slot]      <= req_id;
                addr_q[wr_slot]    <= req_addr;
                gen_q[wr_slot]     <= wr_ptr[PW];
                pending_q[wr_slot] <= 1'b1;
                done_q[wr_slot]    <= 1'b0;
                wr_ptr             <= wr_ptr + (PW+1)'(1);
            end

            // Never collides with the push or pop slot: a write needs pending & !done,
            // a free slot has pending = 0, and a popped head is done or expired.
            if (rsp_write) begin
                data_q[rsp_slot]    <= mem_rsp_data;
                done_q[rsp_slot]    <= 1'b1;
                pending_q[rsp_slot] <= 1'b0;
            end

            if (pop) begin
                pending_q[head] <= 1'b0;
                done_q[head]    <= 1'b0;
                rd_ptr          <= rd_ptr + (PW+1)'(1);
            end
        end
    end

endmodule
